// File: rtl/dbus_bridge_pkg.sv
// Shared types for the data-side bus bridge: memory-stage request records,
// access-size encoding and FSM state constants.
package dbus_bridge_pkg;

    typedef enum logic [1:0] {
        MSIZE_B = 2'b00,
        MSIZE_H = 2'b01,
        MSIZE_W = 2'b10
    } msize_t;

    typedef struct packed {
        logic        ren;
        logic [31:0] addr;
        msize_t      size;
    } m_r_t;

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wd;
        msize_t      size;
    } m_w_t;

    // FSM states kept as plain constants so older tools and netlists
    // see a fixed two-bit encoding.
    typedef logic [1:0] dbus_state_t;
    localparam dbus_state_t ST_IDLE = 2'd0;
    localparam dbus_state_t ST_ADDR = 2'd1;
    localparam dbus_state_t ST_DATA = 2'd2;
    localparam dbus_state_t ST_DONE = 2'd3;

endpackage

// File: rtl/dbus_bridge_if.sv
// SRAM-like data port toward the AXI crossbar (req/addr_ok/data_ok).
interface dbus_bridge_if;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );

endinterface

// File: rtl/dbus_bridge_vaddr_map.sv
// Fixed-mapping virtual-to-physical translation for kseg0/kseg1.
// Purely combinational so it can be shared with an instruction-side bridge.
module vaddr_map #(
    parameter bit MAP_KSEG = 1'b1
) (
    input  logic [31:0] i_vaddr,
    output logic [31:0] o_paddr
);

    logic w_kseg01;

    // kseg0 (100) and kseg1 (101) both alias the low 512 MB of physical space.
    assign w_kseg01 = (i_vaddr[31:29] == 3'b100) || (i_vaddr[31:29] == 3'b101);
    assign o_paddr  = (MAP_KSEG && w_kseg01) ? {3'b000, i_vaddr[28:0]} : i_vaddr;

endmodule

// File: rtl/dbus_bridge.sv
// Data-side bridge: turns a memory-stage read/write request into one
// SRAM-like transaction, stalls the pipeline while it is in flight and
// holds the raw read word for writeback.
module dbus_bridge
    import dbus_bridge_pkg::*;
#(
    parameter bit          MAP_KSEG = 1'b1,
    parameter logic [31:0] RESET_RD = 32'h0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  m_r_t                 mread,
    input  m_w_t                 mwrite,
    input  logic                 cancel,
    input  logic                 advance,
    output logic [31:0]          rd,
    output logic                 d_stall,
    dbus_bridge_if.master        dbus
);

    dbus_state_t r_state;
    logic        r_discard;
    logic        r_req;
    logic        r_wr;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rd;

    logic        w_hit;
    logic        w_is_wr;
    logic [31:0] w_vaddr;
    logic [31:0] w_paddr;
    logic [1:0]  w_size;
    logic        w_drop;
    logic        w_resp_done;

    // A write wins if both enables are (illegally) set together.
    assign w_hit   = (mread.ren | mwrite.wen) & ~cancel;
    assign w_is_wr = mwrite.wen;
    assign w_vaddr = w_is_wr ? mwrite.addr : mread.addr;
    assign w_size  = w_is_wr ? mwrite.size : mread.size;

    // A flush seen at any point of the transaction, including its last cycle,
    // means the result belongs to an instruction that no longer exists.
    assign w_drop = r_discard | cancel;

    assign w_resp_done = ((r_state == ST_ADDR) && dbus.data_addr_ok && dbus.data_data_ok) ||
                         ((r_state == ST_DATA) && dbus.data_data_ok);

    vaddr_map #(
        .MAP_KSEG (MAP_KSEG)
    ) u_vaddr_map (
        .i_vaddr (w_vaddr),
        .o_paddr (w_paddr)
    );

    // Stall request: raised in the very cycle a request appears, dropped once done.
    always_comb begin
        // NOTE: default assignment first so no path leaves d_stall unassigned (no latch).
        d_stall = 1'b0;
        case (r_state)
            ST_IDLE:          d_stall = w_hit;
            ST_ADDR, ST_DATA: d_stall = 1'b1;
            default:          d_stall = 1'b0;
        endcase
    end

    // Transaction sequencing; DONE waits for the M stage to move on so the
    // same held request is never reissued.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_hit) r_state <= ST_ADDR;
                ST_ADDR: begin
                    if (dbus.data_addr_ok) begin
                        if (dbus.data_data_ok) r_state <= w_drop ? ST_IDLE : ST_DONE;
                        else                   r_state <= ST_DATA;
                    end
                end
                ST_DATA: if (dbus.data_data_ok) r_state <= w_drop ? ST_IDLE : ST_DONE;
                default: if (advance) r_state <= ST_IDLE;
            endcase
        end
    end

    // Request registers: loaded on issue, held stable until the slave accepts.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_req   <= 1'b0;
            r_wr    <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
        end else if (r_state == ST_IDLE && w_hit) begin
            r_req   <= 1'b1;
            r_wr    <= w_is_wr;
            r_size  <= w_size;
            r_addr  <= w_paddr;
            r_wdata <= mwrite.wd;
        end else if (r_state == ST_ADDR && dbus.data_addr_ok) begin
            r_req   <= 1'b0;
        end
    end

    // Flush tracking: a cancel during an in-flight transaction marks its result void.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_discard <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_discard <= 1'b0;
        end else if ((r_state == ST_ADDR || r_state == ST_DATA) && cancel) begin
            r_discard <= 1'b1;
        end
    end

    // Read data capture: raw word, only for reads that were not flushed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd <= RESET_RD;
        end else if (w_resp_done && !r_wr && !w_drop) begin
            r_rd <= dbus.data_rdata;
        end
    end

    assign rd              = r_rd;
    assign dbus.data_req   = r_req;
    assign dbus.data_wr    = r_wr;
    assign dbus.data_size  = r_size;
    assign dbus.data_addr  = r_addr;
    assign dbus.data_wdata = r_wdata;

endmodule
